// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle ARM datapath: sequences fetch/decode/execute,
// owns the NZCV flag register and gates every architectural write by the latched condition.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic [3:0] alu_flags,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       adr_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_control,
  output logic [1:0] imm_src,
  output logic [1:0] reg_src,
  output logic [3:0] state,
  output logic       N,
  output logic       Z,
  output logic       CO,
  output logic       OVF
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExecR  = 4'd6,
    StExecI  = 4'd7,
    StAluWb  = 4'd8,
    StBranch = 4'd9
  } state_e;

  state_e     state_q, state_d;
  logic       condex, condex_q;
  logic [3:0] flags_q, flags_d;  // {N, Z, C, V}
  logic [1:0] cmd_alu;
  logic       cmd_valid, cmd_cmp, cmd_cv;
  logic       flag_we, rd_pc;

  assign rd_pc = (rd == 4'hF);

  // Condition check against the registered flags.
  always_comb begin
    condex = 1'b0;
    unique case (cond)
      4'b0000: condex = flags_q[2];
      4'b0001: condex = ~flags_q[2];
      4'b0010: condex = flags_q[1];
      4'b0011: condex = ~flags_q[1];
      4'b0100: condex = flags_q[3];
      4'b0101: condex = ~flags_q[3];
      4'b0110: condex = flags_q[0];
      4'b0111: condex = ~flags_q[0];
      4'b1000: condex = flags_q[1] & ~flags_q[2];
      4'b1001: condex = ~flags_q[1] | flags_q[2];
      4'b1010: condex = (flags_q[3] == flags_q[0]);
      4'b1011: condex = (flags_q[3] != flags_q[0]);
      4'b1100: condex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'b1101: condex = flags_q[2] | (flags_q[3] != flags_q[0]);
      4'b1110: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

  always_comb begin
    cmd_alu   = 2'b00;
    cmd_valid = 1'b0;
    cmd_cmp   = 1'b0;
    cmd_cv    = 1'b0;
    case (funct[4:1])
      4'b0100: begin cmd_alu = 2'b00; cmd_valid = 1'b1; cmd_cv = 1'b1; end
      4'b0010: begin cmd_alu = 2'b01; cmd_valid = 1'b1; cmd_cv = 1'b1; end
      4'b0000: begin cmd_alu = 2'b10; cmd_valid = 1'b1; end
      4'b1100: begin cmd_alu = 2'b11; cmd_valid = 1'b1; end
      4'b1010: begin cmd_alu = 2'b01; cmd_valid = 1'b1; cmd_cv = 1'b1; cmd_cmp = 1'b1; end
      default: ;
    endcase
  end

  // CMP writes flags regardless of S; unknown commands never do.
  assign flag_we = ((state_q == StExecR) || (state_q == StExecI)) && condex_q && cmd_valid &&
                   (funct[0] || cmd_cmp);

  always_comb begin
    flags_d = flags_q;
    if (flag_we) begin
      flags_d[3:2] = alu_flags[3:2];
      if (cmd_cv) flags_d[1:0] = alu_flags[1:0];
    end
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        case (op)
          2'b00:   state_d = funct[5] ? StExecI : StExecR;
          2'b01:   state_d = StMemAdr;
          2'b10:   state_d = StBranch;
          default: state_d = StFetch;
        endcase
      end
      StMemAdr: state_d = funct[0] ? StMemRd : StMemWr;
      StMemRd:  state_d = StMemWb;
      StExecR:  state_d = StAluWb;
      StExecI:  state_d = StAluWb;
      default:  state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StFetch;
      flags_q  <= 4'b0000;
      condex_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      if (state_q == StDecode) condex_q <= condex;
    end
  end

  always_comb begin
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    alu_control = 2'b00;
    case (state_q)
      StFetch: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      StDecode: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      StMemAdr: alu_src_b = 2'b01;
      StMemRd:  adr_src = 1'b1;
      StMemWb: begin
        result_src = 2'b01;
        reg_write  = condex_q;
        pc_write   = condex_q & rd_pc;
      end
      StMemWr: begin
        adr_src   = 1'b1;
        mem_write = condex_q;
      end
      StExecR: alu_control = cmd_alu;
      StExecI: begin
        alu_src_b   = 2'b01;
        alu_control = cmd_alu;
      end
      StAluWb: begin
        reg_write = condex_q & ~cmd_cmp;
        pc_write  = condex_q & ~cmd_cmp & rd_pc;
      end
      StBranch: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = condex_q;
      end
      default: ;
    endcase
  end

  assign imm_src = op;
  assign reg_src = {op == 2'b01, op == 2'b10};
  assign state   = state_q;
  assign N       = flags_q[3];
  assign Z       = flags_q[2];
  assign CO      = flags_q[1];
  assign OVF     = flags_q[0];

endmodule
